block_alloc_arbiter: RTL and testbench

- Sits in front of the free-block pool (bitmap of free erase blocks, 1 = free) and shares it between REQS requesters, e.g. host write path and garbage collector.
- Arbitrates round-robin, finds the lowest-index free block and returns it with a handshake.
- Issues the allocate pulse to the pool and forwards block-free requests to it.
- Reports a registered free-block count and a low-space flag for GC triggering.

---
 rtl/flash_ctrl_pkg.sv | 20 ++
 rtl/block_alloc_arbiter_rr_arbiter.sv | 39 +++
 rtl/block_alloc_arbiter.sv | 164 ++++++++++++++++
 tb/tb_block_alloc_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_ctrl_pkg.sv
// flash_ctrl_pkg
// Shared types and constants for the flash controller block-allocation path.
//   alloc_state_t : allocation arbiter FSM states
//   BLOCKS_DEFAULT, REQS_DEFAULT, LOW_WM_DEFAULT : default geometry
//   BLK_W         : block-index width for the default geometry
package flash_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    GRANT  = 2'd2,
    SETTLE = 2'd3
  } alloc_state_t;

  localparam int BLOCKS_DEFAULT = 64;
  localparam int REQS_DEFAULT   = 2;
  localparam int LOW_WM_DEFAULT = 4;
  localparam int BLK_W          = $clog2(BLOCKS_DEFAULT);

endpackage

// File: rtl/block_alloc_arbiter_rr_arbiter.sv
// rr_arbiter
// Combinational round-robin arbiter. The search starts one position after
// rr_ptr and wraps, so the most recent winner has the lowest priority.
//   req    in  REQS   request vector
//   rr_ptr in  PTR_W  index of the previous winner
//   grant  out REQS   one-hot winner, all zero when req == 0
module rr_arbiter #(
  parameter int REQS  = 2,
  parameter int PTR_W = $clog2(REQS)
) (
  input  logic [REQS-1:0]  req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [REQS-1:0]  grant
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;
  logic             done;

  always_comb begin
    grant = '0;
    done  = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 1; k <= REQS; k++) begin
      // rr_ptr + k stays below 2*REQS, so one conditional subtract wraps it
      sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(REQS)) begin
        sum = sum - (PTR_W+1)'(REQS);
      end
      idx = sum[PTR_W-1:0];
      if (!done && req[idx]) begin
        grant[idx] = 1'b1;
        done       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/block_alloc_arbiter.sv
// block_alloc_arbiter
// Shares the free-block pool between REQS requesters. A round-robin winner
// is latched, the lowest free block is located, and the winner is acked with
// either the block (and an allocate strobe to the pool) or an exhausted
// indication. Block releases are forwarded to the pool with one cycle of
// latency, and a registered free count / low-space flag is kept for GC.
//   clk              in   system clock
//   reset            in   synchronous active-high reset
//   req              in   per-requester allocation request (level)
//   ack              out  one-hot one-cycle completion pulse
//   ack_ok           out  with ack: 1 = block granted, 0 = pool exhausted
//   ack_block        out  granted block index
//   free_req         in   release request
//   free_blk         in   block index to release
//   free_bitmap      in   pool free bitmap, 1 = free
//   pool_alloc       out  allocate strobe to pool
//   pool_alloc_block out  block to allocate
//   pool_free        out  free strobe to pool
//   pool_free_block  out  block to free
//   free_count       out  registered popcount of free_bitmap
//   low_space        out  registered free_count < LOW_WM
//
// state  | meaning
// IDLE   | waiting for any req; latches the round-robin winner
// SCAN   | locates lowest free block; registers ack/alloc outputs
// GRANT  | ack and pool_alloc visible; rr pointer moves to winner
// SETTLE | lets the pool bitmap absorb the allocation
module block_alloc_arbiter
  import flash_ctrl_pkg::*;
#(
  parameter int BLOCKS = BLOCKS_DEFAULT,
  parameter int REQS   = REQS_DEFAULT,
  parameter int LOW_WM = LOW_WM_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [REQS-1:0]           req,
  output logic [REQS-1:0]           ack,
  output logic                      ack_ok,
  output logic [$clog2(BLOCKS)-1:0] ack_block,
  input  logic                      free_req,
  input  logic [$clog2(BLOCKS)-1:0] free_blk,
  input  logic [BLOCKS-1:0]         free_bitmap,
  output logic                      pool_alloc,
  output logic [$clog2(BLOCKS)-1:0] pool_alloc_block,
  output logic                      pool_free,
  output logic [$clog2(BLOCKS)-1:0] pool_free_block,
  output logic [$clog2(BLOCKS):0]   free_count,
  output logic                      low_space
);

  localparam int BW    = $clog2(BLOCKS);
  localparam int PTR_W = $clog2(REQS);

  function automatic logic [BW-1:0] lowest_set(input logic [BLOCKS-1:0] v);
    logic [BLOCKS-1:0] sh;
    lowest_set = '0;
    for (int i = BLOCKS - 1; i >= 0; i--) begin
      sh = v >> i;
      if (sh[0]) lowest_set = BW'(i);
    end
  endfunction

  function automatic logic [BW:0] popcount(input logic [BLOCKS-1:0] v);
    logic [BLOCKS-1:0] sh;
    popcount = '0;
    for (int i = 0; i < BLOCKS; i++) begin
      sh       = v >> i;
      popcount = popcount + (BW+1)'(sh[0]);
    end
  endfunction

  function automatic logic [PTR_W-1:0] onehot_idx(input logic [REQS-1:0] oh);
    logic [REQS-1:0] sh;
    onehot_idx = '0;
    for (int i = 0; i < REQS; i++) begin
      sh = oh >> i;
      if (sh[0]) onehot_idx = PTR_W'(i);
    end
  endfunction

  alloc_state_t     state;
  logic [PTR_W-1:0] rr_ptr;
  logic [REQS-1:0]  grant;
  logic [REQS-1:0]  winner_oh;
  logic             any_free;
  logic [BW-1:0]    first_free;
  logic [BW:0]      count_next;

  rr_arbiter #(
    .REQS  (REQS),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req    (req),
    .rr_ptr (rr_ptr),
    .grant  (grant)
  );

  assign any_free   = |free_bitmap;
  assign first_free = lowest_set(free_bitmap);
  assign count_next = popcount(free_bitmap);

  // Ack/alloc outputs are loaded on the SCAN->GRANT edge so they are
  // registered and visible for exactly the GRANT cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      rr_ptr           <= PTR_W'(REQS - 1);
      winner_oh        <= '0;
      ack              <= '0;
      ack_ok           <= 1'b0;
      ack_block        <= '0;
      pool_alloc       <= 1'b0;
      pool_alloc_block <= '0;
    end else begin
      ack              <= '0;
      ack_ok           <= 1'b0;
      ack_block        <= '0;
      pool_alloc       <= 1'b0;
      pool_alloc_block <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            winner_oh <= grant;
            state     <= SCAN;
          end
        end
        SCAN: begin
          ack              <= winner_oh;
          ack_ok           <= any_free;
          ack_block        <= any_free ? first_free : '0;
          pool_alloc       <= any_free;
          pool_alloc_block <= any_free ? first_free : '0;
          state            <= GRANT;
        end
        GRANT: begin
          rr_ptr <= onehot_idx(winner_oh);
          state  <= SETTLE;
        end
        SETTLE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pool_free       <= 1'b0;
      pool_free_block <= '0;
      free_count      <= '0;
      low_space       <= 1'b0;
    end else begin
      pool_free       <= free_req;
      pool_free_block <= free_blk;
      free_count      <= count_next;
      low_space       <= (int'(count_next) < LOW_WM);
    end
  end

endmodule

// File: tb/tb_block_alloc_arbiter.sv
module tb_block_alloc_arbiter;
  import flash_ctrl_pkg::*;

  localparam int BLOCKS = 64;
  localparam int REQS   = 2;
  localparam int LOW_WM = 4;
  localparam int BW     = BLK_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [REQS-1:0]   req = '0;
  logic [REQS-1:0]   ack;
  logic              ack_ok;
  logic [BW-1:0]     ack_block;
  logic              free_req = 1'b0;
  logic [BW-1:0]     free_blk = '0;
  logic [BLOCKS-1:0] free_bitmap = '0;
  logic              pool_alloc;
  logic [BW-1:0]     pool_alloc_block;
  logic              pool_free;
  logic [BW-1:0]     pool_free_block;
  logic [BW:0]       free_count;
  logic              low_space;

  block_alloc_arbiter #(.BLOCKS(BLOCKS), .REQS(REQS), .LOW_WM(LOW_WM)) dut (
    .clk(clk), .reset(reset), .req(req), .ack(ack), .ack_ok(ack_ok),
    .ack_block(ack_block), .free_req(free_req), .free_blk(free_blk),
    .free_bitmap(free_bitmap), .pool_alloc(pool_alloc),
    .pool_alloc_block(pool_alloc_block), .pool_free(pool_free),
    .pool_free_block(pool_free_block), .free_count(free_count),
    .low_space(low_space)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Pool environment: the bitmap for the next cycle is this cycle's bitmap
  // with the expected alloc/free strobes applied, unless the stimulus forces it.
  logic [BLOCKS-1:0] pool_next = '0;
  logic              force_bm = 1'b0;
  logic [BLOCKS-1:0] force_val = '0;

  task automatic tick();
    @(posedge clk);
    #1;
    free_bitmap = force_bm ? force_val : pool_next;
  endtask

  // Reference model: transaction-level view of the arbiter.
  logic [REQS-1:0] e_ack = '0;
  logic            e_ok = 1'b0, e_alloc = 1'b0, e_pf = 1'b0, e_low = 1'b0;
  logic [BW-1:0]   e_blk = '0, e_pfb = '0;
  logic [BW:0]     e_cnt = '0;
  bit              m_valid = 0;
  int              last_w = REQS - 1;
  int              busy = 0;
  bit              scan_pend = 0;
  int              scan_w = 0;

  function automatic int pick(input logic [REQS-1:0] r, input int last);
    logic [REQS-1:0] sh;
    for (int k = 1; k <= REQS; k++) begin
      sh = r >> ((last + k) % REQS);
      if (sh[0]) return (last + k) % REQS;
    end
    return -1;
  endfunction

  function automatic int lowest_free(input logic [BLOCKS-1:0] v);
    logic [BLOCKS-1:0] sh;
    for (int i = 0; i < BLOCKS; i++) begin
      sh = v >> i;
      if (sh[0]) return i;
    end
    return 0;
  endfunction

  always @(negedge clk) begin
    logic [REQS-1:0]   n_ack;
    logic              n_ok, n_alloc, n_pf, n_low;
    logic [BW-1:0]     n_blk, n_pfb;
    logic [BW:0]       n_cnt;
    logic [BLOCKS-1:0] pn;
    int                cnt;
    int                w;

    if (m_valid) begin
      chk("m_ack", ack, e_ack);
      chk("m_pool_alloc", pool_alloc, e_alloc);
      chk("m_pool_free", pool_free, e_pf);
      chk("m_free_count", free_count, e_cnt);
      chk("m_low_space", low_space, e_low);
      if (e_ack != 0) begin
        chk("m_ack_ok", ack_ok, e_ok);
        chk("m_ack_block", ack_block, e_blk);
      end
      if (e_alloc) chk("m_pool_alloc_block", pool_alloc_block, e_blk);
      if (e_pf) chk("m_pool_free_block", pool_free_block, e_pfb);
    end

    pn = free_bitmap;
    if (e_alloc) pn[e_blk] = 1'b0;
    if (e_pf) pn[e_pfb] = 1'b1;
    pool_next = pn;

    n_ack = '0; n_ok = 0; n_alloc = 0; n_pf = 0; n_low = 0;
    n_blk = '0; n_pfb = '0; n_cnt = '0;
    if (reset) begin
      busy = 0;
      last_w = REQS - 1;
      scan_pend = 0;
      m_valid = 1;
    end else begin
      n_pf  = free_req;
      n_pfb = free_blk;
      cnt   = $countones(free_bitmap);
      n_cnt = (BW+1)'(cnt);
      n_low = (cnt < LOW_WM);
      if (scan_pend) begin
        n_ack     = REQS'(1) << scan_w;
        n_ok      = (free_bitmap != 0);
        n_blk     = (free_bitmap != 0) ? BW'(lowest_free(free_bitmap)) : '0;
        n_alloc   = n_ok;
        scan_pend = 0;
      end
      if (busy > 0) begin
        busy--;
      end else if (req != 0) begin
        w         = pick(req, last_w);
        last_w    = w;
        scan_w    = w;
        scan_pend = 1;
        busy      = 3;
      end
    end
    e_ack = n_ack; e_ok = n_ok; e_blk = n_blk; e_alloc = n_alloc;
    e_pf = n_pf; e_pfb = n_pfb; e_cnt = n_cnt; e_low = n_low;
  end

  // Leaves the bench in the first cycle after two reset cycles, bitmap = bm.
  task automatic do_reset(input logic [BLOCKS-1:0] bm);
    reset = 1'b1; req = '0; free_req = 1'b0;
    force_bm = 1'b1; force_val = bm;
    tick(); tick();
    reset = 1'b0; force_bm = 1'b0;
  endtask

  function automatic logic [BLOCKS-1:0] rand_bitmap();
    logic [BLOCKS-1:0] a, b, c;
    a = {$urandom(), $urandom()};
    b = {$urandom(), $urandom()};
    c = {$urandom(), $urandom()};
    case ($urandom_range(0, 4))
      0: return '0;
      1: return a;
      2: return a & b & c;
      3: return BLOCKS'(1) << $urandom_range(0, BLOCKS - 1);
      default: return BLOCKS'(4'hF) << $urandom_range(0, 8);
    endcase
  endfunction

  initial begin
    logic [REQS-1:0] exp_ack;

    // Basic grant from reset, requester 0 first.
    do_reset({BLOCKS{1'b1}});
    req = 2'b01;
    @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_pool_alloc", pool_alloc, 0);
    chk("rst_free_count", free_count, 0);
    chk("rst_low_space", low_space, 0);
    tick(); tick();
    req = 2'b00;
    @(negedge clk);
    chk("t1_ack", ack, 2'b01);
    chk("t1_ack_ok", ack_ok, 1);
    chk("t1_ack_block", ack_block, 0);
    chk("t1_pool_alloc", pool_alloc, 1);
    chk("t1_pool_alloc_block", pool_alloc_block, 0);
    chk("t1_free_count", free_count, 64);
    chk("t1_low_space", low_space, 0);

    // Both requesters held: alternate winners, ascending blocks.
    do_reset({BLOCKS{1'b1}});
    req = 2'b11;
    tick(); tick();
    for (int k = 0; k < 4; k++) begin
      exp_ack = (k % 2 == 0) ? 2'b01 : 2'b10;
      @(negedge clk);
      chk("t2_ack", ack, exp_ack);
      chk("t2_ack_block", ack_block, k);
      if (k < 3) begin
        tick(); tick(); tick(); tick();
      end
    end
    req = 2'b00;

    // Exhausted pool.
    do_reset('0);
    req = 2'b10;
    tick(); tick();
    req = 2'b00;
    @(negedge clk);
    chk("t3_ack", ack, 2'b10);
    chk("t3_ack_ok", ack_ok, 0);
    chk("t3_pool_alloc", pool_alloc, 0);
    chk("t3_free_count", free_count, 0);
    chk("t3_low_space", low_space, 1);

    // Single free block plus a free in the GRANT cycle.
    do_reset(BLOCKS'(1) << 37);
    req = 2'b01;
    tick(); tick();
    free_req = 1'b1; free_blk = 6'd5;
    @(negedge clk);
    chk("t4_ack_block", ack_block, 37);
    chk("t4_pool_alloc", pool_alloc, 1);
    chk("t4_pool_alloc_block", pool_alloc_block, 37);
    tick();
    free_req = 1'b0; req = 2'b00;
    @(negedge clk);
    chk("t4_pool_free", pool_free, 1);
    chk("t4_pool_free_block", pool_free_block, 5);
    tick(); tick();
    @(negedge clk);
    chk("t4_free_count", free_count, 1);

    // Low-space threshold crossing.
    do_reset(BLOCKS'(4'hF));
    tick();
    req = 2'b01;
    @(negedge clk);
    chk("t5_count4", free_count, 4);
    chk("t5_low0", low_space, 0);
    tick(); tick(); tick();
    req = 2'b00;
    @(negedge clk);
    chk("t5_count_lag", free_count, 4);
    tick();
    @(negedge clk);
    chk("t5_count3", free_count, 3);
    chk("t5_low1", low_space, 1);

    // Reset during SCAN drops the request; held req is re-served.
    do_reset({BLOCKS{1'b1}});
    req = 2'b01;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("t6_ack_after_rst", ack, 0);
    chk("t6_alloc_after_rst", pool_alloc, 0);
    tick(); tick();
    req = 2'b00;
    @(negedge clk);
    chk("t6_ack", ack, 2'b01);
    chk("t6_ack_ok", ack_ok, 1);
    chk("t6_ack_block", ack_block, 0);

    // Randomised traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      force_bm = ($urandom_range(0, 39) == 0);
      if (force_bm) force_val = rand_bitmap();
      tick();
      reset    = ($urandom_range(0, 299) == 0);
      req      = REQS'($urandom());
      free_req = ($urandom_range(0, 3) == 0);
      free_blk = BW'($urandom_range(0, BLOCKS - 1));
    end
    force_bm = 1'b0; req = '0; free_req = 1'b0; reset = 1'b0;
    for (int i = 0; i < 8; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
